// File: rtl/muldiv_wb_queue.sv
// muldiv_wb_queue: writeback queue for RV32M MULDIV results.
// Buffers (rd, data) pairs in a small FIFO and merges them onto the single
// register-file write port shared with the main integer pipeline. A starvation
// counter stalls the main pipeline when the queue head has waited too long.
// Optional feature: define MDWB_BYPASS_EN to write an accepted result in the
// same cycle when the queue is empty and the ALU is not using the port.
module muldiv_wb_queue #(
  parameter int XLEN         = 32,
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     md_valid,
  output logic                     md_ready,
  input  logic [4:0]               md_rd,
  input  logic [XLEN-1:0]          md_result,
  input  logic                     alu_wr_valid,
  input  logic [4:0]               alu_rd,
  input  logic [XLEN-1:0]          alu_data,
  output logic                     alu_stall,
  output logic                     rf_we,
  output logic [4:0]               rf_waddr,
  output logic [XLEN-1:0]          rf_wdata,
  output logic [31:0]              busy_mask,
  output logic [$clog2(DEPTH):0]   q_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  logic [4:0]      r_rd   [DEPTH];
  logic [XLEN-1:0] r_data [DEPTH];
  logic [AW-1:0]   r_wptr;
  logic [AW-1:0]   r_rptr;
  logic [CW-1:0]   r_count;
  logic [SW-1:0]   r_starve;

  logic w_empty;
  logic w_stall;
  logic w_acc;
  logic w_byp;
  logic w_enq;
  logic w_deq;

  // md_ready comes only from registered occupancy, so a same-cycle dequeue
  // never opens a slot for a full queue.
  assign md_ready  = (r_count < CW'(DEPTH));
  assign w_empty   = (r_count == '0);
  assign w_stall   = !w_empty && (r_starve >= SW'(STARVE_LIMIT));
  assign w_acc     = md_valid && md_ready;
`ifdef MDWB_BYPASS_EN
  assign w_byp     = w_acc && (md_rd != 5'd0) && w_empty && !alu_wr_valid;
`else
  assign w_byp     = 1'b0;
`endif
  // rd==0 results complete the handshake but are dropped.
  assign w_enq     = w_acc && (md_rd != 5'd0) && !w_byp;
  // Head drains when forced by starvation or when the ALU leaves the port idle.
  assign w_deq     = !w_empty && (w_stall || !alu_wr_valid);
  assign alu_stall = w_stall;
  assign q_count   = r_count;

  // Write-port mux: starved head, then ALU, then head, then bypass.
  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = 5'd0;
    rf_wdata = '0;
    if (w_deq) begin
      rf_we    = 1'b1;
      rf_waddr = r_rd[r_rptr];
      rf_wdata = r_data[r_rptr];
    end else if (alu_wr_valid) begin
      rf_we    = 1'b1;
      rf_waddr = alu_rd;
      rf_wdata = alu_data;
    end else if (w_byp) begin
      rf_we    = 1'b1;
      rf_waddr = md_rd;
      rf_wdata = md_result;
    end
  end

  // Busy mask: one-hot rd of every slot inside the occupied window [rptr, rptr+count).
  always_comb begin
    logic [AW-1:0] v_off;
    busy_mask = 32'd0;
    v_off     = '0;
    for (int i = 0; i < DEPTH; i++) begin
      v_off = AW'(i) - r_rptr;
      if ({1'b0, v_off} < r_count) begin
        busy_mask[r_rd[i]] = 1'b1;
      end
    end
    busy_mask[0] = 1'b0;
  end

  // Queue control: pointers, occupancy and head starvation counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_count  <= '0;
      r_starve <= '0;
    end else begin
      if (w_enq) begin
        r_wptr <= r_wptr + AW'(1);
      end
      if (w_deq) begin
        r_rptr <= r_rptr + AW'(1);
      end
      case ({w_enq, w_deq})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      if (!w_empty && !w_deq) begin
        if (r_starve < SW'(STARVE_LIMIT)) begin
          r_starve <= r_starve + SW'(1);
        end
      end else begin
        r_starve <= '0;
      end
    end
  end

  // Entry storage: written on enqueue only, validity tracked by the pointers.
  always_ff @(posedge clk) begin
    if (w_enq) begin
      r_rd[r_wptr]   <= md_rd;
      r_data[r_wptr] <= md_result;
    end
  end

  // Issue logic must never send an ALU write to a destination still queued here.
  a_alu_not_busy: assert property (@(posedge clk) disable iff (!rst_n)
    !(alu_wr_valid && busy_mask[alu_rd]));

endmodule

// File: tb/tb_muldiv_wb_queue.sv
// Testbench for muldiv_wb_queue: directed scenarios plus randomized traffic,
// checked every cycle against a queue-based behavioural model.
module tb_muldiv_wb_queue;

  localparam int XLEN  = 32;
  localparam int DEPTH = 4;
  localparam int LIM   = 8;

  logic             clk;
  logic             rst_n;
  logic             md_valid;
  logic             md_ready;
  logic [4:0]       md_rd;
  logic [XLEN-1:0]  md_result;
  logic             alu_wr_valid;
  logic [4:0]       alu_rd;
  logic [XLEN-1:0]  alu_data;
  logic             alu_stall;
  logic             rf_we;
  logic [4:0]       rf_waddr;
  logic [XLEN-1:0]  rf_wdata;
  logic [31:0]      busy_mask;
  logic [2:0]       q_count;

  muldiv_wb_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .STARVE_LIMIT(LIM)) dut (
    .clk(clk), .rst_n(rst_n),
    .md_valid(md_valid), .md_ready(md_ready), .md_rd(md_rd), .md_result(md_result),
    .alu_wr_valid(alu_wr_valid), .alu_rd(alu_rd), .alu_data(alu_data),
    .alu_stall(alu_stall), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .busy_mask(busy_mask), .q_count(q_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  ent_t mq[$];
  int   mstarve;
  int   checks;
  int   errors;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mbusy();
    logic [31:0] b;
    b = 32'd0;
    foreach (mq[i]) b[mq[i].rd] = 1'b1;
    b[0] = 1'b0;
    return b;
  endfunction

  task automatic set_idle();
    md_valid = 1'b0; md_rd = 5'd0; md_result = '0;
    alu_wr_valid = 1'b0; alu_rd = 5'd0; alu_data = '0;
  endtask

  // Compare all outputs against the model for the current inputs.
  task automatic sample();
    int n;
    logic stall, ready, we;
    logic [4:0] wa;
    logic [31:0] wd;
    @(negedge clk);
    n = mq.size();
    stall = (mstarve >= LIM) && (n > 0);
    ready = (n < DEPTH);
    we = 1'b0; wa = 5'd0; wd = 32'd0;
    if (n > 0 && (stall || !alu_wr_valid)) begin
      we = 1'b1; wa = mq[0].rd; wd = mq[0].data;
    end else if (alu_wr_valid) begin
      we = 1'b1; wa = alu_rd; wd = alu_data;
    end
`ifdef MDWB_BYPASS_EN
    else if (md_valid && ready && md_rd != 5'd0) begin
      we = 1'b1; wa = md_rd; wd = md_result;
    end
`endif
    chk("md_ready", 64'(md_ready), 64'(ready));
    chk("alu_stall", 64'(alu_stall), 64'(stall));
    chk("rf_we", 64'(rf_we), 64'(we));
    chk("rf_waddr", 64'(rf_waddr), 64'(wa));
    chk("rf_wdata", 64'(rf_wdata), 64'(wd));
    chk("busy_mask", 64'(busy_mask), 64'(mbusy()));
    chk("q_count", 64'(q_count), 64'(n));
  endtask

  // Advance the model across the next rising edge.
  task automatic advance();
    int n;
    logic ready, deq, acc, byp;
    n = mq.size();
    ready = (n < DEPTH);
    deq = (n > 0) && ((mstarve >= LIM) || !alu_wr_valid);
    acc = md_valid && ready && (md_rd != 5'd0);
    byp = 1'b0;
`ifdef MDWB_BYPASS_EN
    byp = acc && (n == 0) && !alu_wr_valid;
`endif
    if (deq) void'(mq.pop_front());
    if (acc && !byp) mq.push_back('{rd: md_rd, data: md_result});
    mstarve = (n > 0 && !deq) ? mstarve + 1 : 0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not end, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int stalls[$];
    ent_t wlog[$];
    int sent;
    logic found;
    logic [31:0] mb;
    logic [4:0] cand;

    checks = 0; errors = 0; mstarve = 0;
    set_idle();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    // Reset state, with an ALU write passing straight through.
    alu_wr_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h1234;
    #1;
    chk("rst_q_count", 64'(q_count), 64'd0);
    chk("rst_md_ready", 64'(md_ready), 64'd1);
    chk("rst_alu_stall", 64'(alu_stall), 64'd0);
    chk("rst_busy", 64'(busy_mask), 64'd0);
    chk("rst_rf_we_alu", 64'(rf_we), 64'd1);
    set_idle();
    #1;
    chk("rst_rf_we_idle", 64'(rf_we), 64'd0);
    rst_n = 1'b1;

    // Single op rd=5 data=6.
    md_valid = 1'b1; md_rd = 5'd5; md_result = 32'h6;
    sample();
`ifdef MDWB_BYPASS_EN
    chk("t1_byp_we", 64'(rf_we), 64'd1);
    chk("t1_byp_addr", 64'(rf_waddr), 64'd5);
    chk("t1_byp_busy", 64'(busy_mask), 64'd0);
`else
    chk("t1_we_same_cycle", 64'(rf_we), 64'd0);
`endif
    advance();
    set_idle();
    sample();
`ifdef MDWB_BYPASS_EN
    chk("t1_byp_next_we", 64'(rf_we), 64'd0);
`else
    chk("t1_we", 64'(rf_we), 64'd1);
    chk("t1_addr", 64'(rf_waddr), 64'd5);
    chk("t1_data", 64'(rf_wdata), 64'd6);
    chk("t1_busy", 64'(busy_mask), 64'h20);
`endif
    advance();
    sample();
    chk("t1_busy_clear", 64'(busy_mask), 64'd0);
    advance();

    // rd=0 result is consumed and dropped.
    md_valid = 1'b1; md_rd = 5'd0; md_result = 32'hDEAD_BEEF;
    sample();
    chk("t4_ready", 64'(md_ready), 64'd1);
    chk("t4_we", 64'(rf_we), 64'd0);
    advance();
    set_idle();
    sample();
    chk("t4_count", 64'(q_count), 64'd0);
    chk("t4_we_after", 64'(rf_we), 64'd0);
    advance();

    // Fill with the ALU holding the port, then starve the head.
    alu_wr_valid = 1'b1; alu_rd = 5'd10; alu_data = 32'hA0A0;
    for (int i = 1; i <= 4; i++) begin
      md_valid = 1'b1; md_rd = 5'(i); md_result = 32'(i * 256);
      sample();
      advance();
    end
    md_valid = 1'b0; md_rd = 5'd0;
    sample();
    chk("t2_ready", 64'(md_ready), 64'd0);
    chk("t2_count", 64'(q_count), 64'd4);
    chk("t2_busy", 64'(busy_mask), 64'h1E);
    advance();
    for (int c = 5; c < 40; c++) begin
      sample();
      if (alu_stall) begin
        stalls.push_back(c);
        chk("t3_stall_rd", 64'(rf_waddr), 64'(stalls.size()));
      end
      advance();
      if (stalls.size() >= 2) break;
    end
    if (stalls.size() < 2) begin
      checks++; errors++;
      $display("FAIL t3_stall_timeout: saw %0d stalls, expected 2", stalls.size());
    end else begin
      chk("t3_first_stall", 64'(stalls[0]), 64'd9);
      chk("t3_wait_between", 64'(stalls[1] - stalls[0] - 1), 64'd8);
    end
    alu_wr_valid = 1'b0;
    for (int c = 0; c < 6; c++) begin
      sample();
      advance();
    end
    sample();
    chk("t3_drained", 64'(q_count), 64'd0);
    advance();

    // Wrap with alternating ALU writes: seven results must arrive in order.
    sent = 0;
    for (int c = 0; c < 40; c++) begin
      md_valid = (sent < 7);
      md_rd = 5'(11 + sent);
      md_result = 32'h1111 * 32'(11 + sent);
      alu_wr_valid = c[0];
      alu_rd = 5'd20; alu_data = 32'(c);
      sample();
      if (rf_we && rf_waddr >= 5'd11 && rf_waddr <= 5'd17)
        wlog.push_back('{rd: rf_waddr, data: rf_wdata});
      if (md_valid && mq.size() < DEPTH) sent++;
      advance();
    end
    chk("t5_num_writes", 64'(wlog.size()), 64'd7);
    for (int i = 0; i < 7 && i < wlog.size(); i++) begin
      chk("t5_order_rd", 64'(wlog[i].rd), 64'(11 + i));
      chk("t5_order_data", 64'(wlog[i].data), 64'(32'h1111 * 32'(11 + i)));
    end

    // Asynchronous reset with three entries queued.
    set_idle();
    alu_wr_valid = 1'b1; alu_rd = 5'd10;
    for (int i = 0; i < 3; i++) begin
      md_valid = 1'b1; md_rd = 5'(21 + i); md_result = 32'(i);
      sample();
      advance();
    end
    set_idle();
    chk("t6_pre_count", 64'(q_count), 64'd3);
    #1 rst_n = 1'b0;
    #1;
    chk("t6_count", 64'(q_count), 64'd0);
    chk("t6_busy", 64'(busy_mask), 64'd0);
    chk("t6_ready", 64'(md_ready), 64'd1);
    chk("t6_stall", 64'(alu_stall), 64'd0);
    mq.delete();
    mstarve = 0;
    #1 rst_n = 1'b1;

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      md_valid = ($urandom_range(0, 3) != 0);
      md_rd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      md_result = $urandom;
      alu_wr_valid = ($urandom_range(0, 2) == 0);
      mb = mbusy();
      found = 1'b0;
      alu_rd = 5'd0;
      for (int t = 0; t < 32 && !found; t++) begin
        cand = 5'($urandom_range(0, 31));
        if (!mb[cand]) begin
          alu_rd = cand;
          found = 1'b1;
        end
      end
      if (!found) alu_wr_valid = 1'b0;
      alu_data = $urandom;
      sample();
      advance();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
